// File: rtl/nacc_pkg.sv
// nacc_pkg -- shared definitions for the neuromorphic execute unit.
//   Vector geometry constants, FSM state enum, mode encodings, the
//   vl-to-lane-count helper and the lane adder.
//   Optional macro NACC_SAT_EN: when defined, lane_add saturates to
//   0x7FFFFFFF / 0x80000000 instead of wrapping modulo 2^32.
package nacc_pkg;

  localparam int NUM_LANES  = 16;
  localparam int LANE_W     = 32;
  localparam int LPC        = 4;
  localparam int LEAK_SHIFT = 3;
  localparam int SVR_W      = 128;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);
  localparam int CNT_W      = LANE_IDX_W + 1;

  localparam logic MODE_NACC = 1'b0;
  localparam logic MODE_LIF  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [LANE_W-1:0] lane_t;

  // Active lane count: 4 * (vl + 1), i.e. 4, 8, 12 or 16.
  function automatic logic [CNT_W-1:0] vl_to_lanes(input logic [1:0] vl);
    logic [CNT_W-1:0] n;
    n = CNT_W'(vl) + CNT_W'(1);
    return n << 2;
  endfunction

  // Signed lane add; overflow detected from the extra sign bit when saturating.
  function automatic lane_t lane_add(input lane_t a, input lane_t b);
`ifdef NACC_SAT_EN
    logic [LANE_W:0] sum;
    sum = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    if (sum[LANE_W] != sum[LANE_W-1])
      return sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    return lane_t'(sum[LANE_W-1:0]);
`else
    return a + b;
`endif
  endfunction

endpackage

// File: rtl/nacc_exec_unit_if.sv
// nacc_exec_unit_if -- operand/result bundle between ID/EX, the execute
// unit and EX/MEM.
//   master: issuing side (drives start/mode/vl/flush and operands,
//           observes busy/stall/done and results).
//   slave : the execute unit.
interface nacc_exec_unit_if;
  import nacc_pkg::*;

  logic                        start;
  logic                        mode;
  logic [1:0]                  vl;
  logic                        flush;
  logic [NUM_LANES*LANE_W-1:0] cur_in;
  logic [NUM_LANES*LANE_W-1:0] vol_in;
  logic [NUM_LANES*LANE_W-1:0] wvr_in;
  logic [SVR_W-1:0]            svr_in;
  logic [LANE_W-1:0]           vt_in;

  logic                        busy;
  logic                        stall;
  logic                        done;
  logic [NUM_LANES*LANE_W-1:0] cur_out;
  logic [NUM_LANES*LANE_W-1:0] vol_out;
  logic [NUM_LANES-1:0]        spike_out;

  modport master (
    output start, mode, vl, flush, cur_in, vol_in, wvr_in, svr_in, vt_in,
    input  busy, stall, done, cur_out, vol_out, spike_out
  );

  modport slave (
    input  start, mode, vl, flush, cur_in, vol_in, wvr_in, svr_in, vt_in,
    output busy, stall, done, cur_out, vol_out, spike_out
  );

endinterface

// File: rtl/nacc_lane.sv
// nacc_lane -- combinational single-lane datapath.
//   Inputs : mode (NACC/LIF), spike_en (this lane's spike bit), w, cur,
//            vol, vt (signed threshold).
//   Outputs: cur_nxt, vol_nxt, spike.
//   All adds go through lane_add, so NACC_SAT_EN selects saturation.
module nacc_lane
  import nacc_pkg::*;
(
  input  logic  mode,
  input  logic  spike_en,
  input  lane_t w,
  input  lane_t cur,
  input  lane_t vol,
  input  lane_t vt,
  output lane_t cur_nxt,
  output lane_t vol_nxt,
  output logic  spike
);

  lane_t leak;
  lane_t v;

  always_comb begin
    leak    = vol >>> LEAK_SHIFT;
    // leak magnitude never exceeds |vol|/8, so negating it cannot overflow
    v       = lane_add(lane_add(vol, -leak), cur);
    cur_nxt = cur;
    vol_nxt = vol;
    spike   = 1'b0;
    if (mode == MODE_NACC) begin
      cur_nxt = lane_add(cur, spike_en ? w : '0);
    end else begin
      cur_nxt = '0;
      if (v >= vt) begin
        spike   = 1'b1;
        vol_nxt = '0;
      end else begin
        vol_nxt = v;
      end
    end
  end

endmodule

// File: rtl/nacc_exec_unit.sv
// nacc_exec_unit -- multi-cycle NACC / LIF vector execute unit in EX.
//   clk, reset : core clock, synchronous active-high reset.
//   bus (slave): start/mode/vl/flush and vector operands from ID/EX;
//                busy/stall/done and cur_out/vol_out/spike_out to EX/MEM.
//   Processes LPC lanes per RUN cycle; start->done latency N/LPC + 1.
//   Optional macro NACC_SAT_EN enables saturating lane arithmetic.
module nacc_exec_unit
  import nacc_pkg::*;
(
  input logic             clk,
  input logic             reset,
  nacc_exec_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LPC_STEP = CNT_W'(LPC);

  state_t state, state_nxt;
  logic   start_acc;
  logic   show_work;

  logic             mode_r;
  lane_t            vt_r;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] idx;

  lane_t                cur_w [NUM_LANES];
  lane_t                vol_w [NUM_LANES];
  lane_t                wvr_r [NUM_LANES];
  logic [NUM_LANES-1:0] svr_r;
  logic [NUM_LANES-1:0] spk_w;

  lane_t                cur_hold [NUM_LANES];
  lane_t                vol_hold [NUM_LANES];
  logic [NUM_LANES-1:0] spk_hold;

  logic [LANE_IDX_W-1:0] lane_sel [LPC];
  lane_t                 lane_cur [LPC];
  lane_t                 lane_vol [LPC];
  logic                  lane_spk [LPC];

  // Spike bits above NUM_LANES have no lane to gate.
  logic svr_unused;
  assign svr_unused = ^bus.svr_in[SVR_W-1:NUM_LANES];

  assign start_acc = (state == IDLE) && bus.start && !bus.flush;
  // Results are exposed from the working copy during the done cycle and
  // committed to the hold registers at its end; a flush in that cycle
  // suppresses both, so outputs keep their pre-op values.
  assign show_work = (state == DONE) && !bus.flush;

  for (genvar k = 0; k < LPC; k++) begin : g_lane
    assign lane_sel[k] = idx[LANE_IDX_W-1:0] + LANE_IDX_W'(k);
    nacc_lane u_lane (
      .mode     (mode_r),
      .spike_en (svr_r[lane_sel[k]]),
      .w        (wvr_r[lane_sel[k]]),
      .cur      (cur_w[lane_sel[k]]),
      .vol      (vol_w[lane_sel[k]]),
      .vt       (vt_r),
      .cur_nxt  (lane_cur[k]),
      .vol_nxt  (lane_vol[k]),
      .spike    (lane_spk[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = RUN;
      RUN:     if (idx + LPC_STEP >= n_r) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Working registers: loaded on accept, updated LPC lanes per RUN cycle.
  // Lanes at or beyond N are never selected, so they pass through.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r   <= MODE_NACC;
      vt_r     <= '0;
      n_r      <= '0;
      idx      <= '0;
      svr_r    <= '0;
      spk_w    <= '0;
      spk_hold <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        cur_w[i]    <= '0;
        vol_w[i]    <= '0;
        wvr_r[i]    <= '0;
        cur_hold[i] <= '0;
        vol_hold[i] <= '0;
      end
    end else begin
      if (start_acc) begin
        mode_r <= bus.mode;
        vt_r   <= bus.vt_in;
        n_r    <= vl_to_lanes(bus.vl);
        idx    <= '0;
        svr_r  <= bus.svr_in[NUM_LANES-1:0];
        spk_w  <= '0;
        for (int i = 0; i < NUM_LANES; i++) begin
          cur_w[i] <= bus.cur_in[i*LANE_W +: LANE_W];
          vol_w[i] <= bus.vol_in[i*LANE_W +: LANE_W];
          wvr_r[i] <= bus.wvr_in[i*LANE_W +: LANE_W];
        end
      end else if (state == RUN && !bus.flush) begin
        idx <= idx + LPC_STEP;
        for (int k = 0; k < LPC; k++) begin
          cur_w[lane_sel[k]] <= lane_cur[k];
          vol_w[lane_sel[k]] <= lane_vol[k];
          spk_w[lane_sel[k]] <= lane_spk[k];
        end
      end
      if (show_work) begin
        spk_hold <= spk_w;
        for (int i = 0; i < NUM_LANES; i++) begin
          cur_hold[i] <= cur_w[i];
          vol_hold[i] <= vol_w[i];
        end
      end
    end
  end

  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.stall     = bus.busy || start_acc;
  assign bus.done      = show_work;
  assign bus.spike_out = show_work ? spk_w : spk_hold;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_out
    assign bus.cur_out[i*LANE_W +: LANE_W] = show_work ? cur_w[i] : cur_hold[i];
    assign bus.vol_out[i*LANE_W +: LANE_W] = show_work ? vol_w[i] : vol_hold[i];
  end

endmodule

// File: tb/tb_nacc_exec_unit.sv
// tb_nacc_exec_unit -- directed self-checking bench for nacc_exec_unit.
//   Drives the operand interface, checks reset state, NACC/LIF results,
//   latency, flush, overflow (NACC_SAT_EN aware), reset mid-op and
//   back-to-back issue.
module tb_nacc_exec_unit;

  logic clk = 1'b0;
  logic reset;

  nacc_exec_unit_if bus();

  nacc_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_cur, exp_vol, tmp_vec;
  logic [511:0] lif_cur, lif_vol;
  int lat, lat2;
  bit seen_done;

  function automatic logic [511:0] splat(input logic [31:0] x);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = x;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] v,
                               input logic [511:0] cur, input logic [511:0] vol,
                               input logic [511:0] wvr, input logic [127:0] svr,
                               input logic [31:0] vt);
    bus.mode   = m;
    bus.vl     = v;
    bus.cur_in = cur;
    bus.vol_in = vol;
    bus.wvr_in = wvr;
    bus.svr_in = svr;
    bus.vt_in  = vt;
    bus.start  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done is seen; -1 if the budget expires.
  task automatic waitDone(input int max_cycles, input bit drop_start, output int cycles);
    cycles = 0;
    while (cycles < max_cycles) begin
      tick();
      cycles++;
      if (drop_start) bus.start = 1'b0;
      if (bus.done === 1'b1) break;
    end
    if (bus.done !== 1'b1) cycles = -1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.vl     = 2'b00;
    bus.flush  = 1'b0;
    bus.cur_in = '0;
    bus.vol_in = '0;
    bus.wvr_in = '0;
    bus.svr_in = '0;
    bus.vt_in  = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("reset_ctrl", {bus.busy, bus.stall, bus.done}, 3'b000);
    checkOutput("reset_cur", bus.cur_out, '0);
    checkOutput("reset_vol", bus.vol_out, '0);
    checkOutput("reset_spike", bus.spike_out, '0);

    // NACC, vl=3, svr=0xAA with junk in ignored upper bits
    tmp_vec = '0;
    for (int i = 0; i < 16; i++) tmp_vec[i*32 +: 32] = 32'(i);
    exp_vol = '0;
    for (int i = 0; i < 16; i++) exp_vol[i*32 +: 32] = 32'(1000 + i);
    applyStimulus(1'b0, 2'b11, splat(32'd10), exp_vol, tmp_vec,
                  {112'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h00AA}, 32'd0);
    #1;
    checkOutput("nacc_stall_accept", {bus.stall, bus.busy}, 2'b10);
    waitDone(20, 1'b1, lat);
    checkOutput("nacc_latency", 32'(lat), 32'd5);
    exp_cur = splat(32'd10);
    for (int i = 1; i < 8; i += 2) exp_cur[i*32 +: 32] = 32'(10 + i);
    checkOutput("nacc_cur", bus.cur_out, exp_cur);
    checkOutput("nacc_vol", bus.vol_out, exp_vol);
    checkOutput("nacc_spike", bus.spike_out, 16'h0000);
    bus.cur_in = splat(32'd999);
    tick();
    checkOutput("nacc_after_done", {bus.done, bus.busy}, 2'b00);
    checkOutput("nacc_hold_cur", bus.cur_out, exp_cur);

    // LIF, vl=0, vt=100; lane0 107 fires, lane1 93, lane2 exactly 100 fires, lane3 16
    tmp_vec = splat(32'd80);
    tmp_vec[0*32 +: 32] = 32'd88;
    tmp_vec[1*32 +: 32] = 32'd72;
    tmp_vec[3*32 +: 32] = 32'hFFFF_FFF0;
    applyStimulus(1'b1, 2'b00, splat(32'd30), tmp_vec, splat(32'd1), 128'hFFFF, 32'd100);
    waitDone(20, 1'b1, lat);
    checkOutput("lif_latency", 32'(lat), 32'd2);
    lif_cur = splat(32'd30);
    for (int i = 0; i < 4; i++) lif_cur[i*32 +: 32] = 32'd0;
    lif_vol = splat(32'd80);
    lif_vol[0*32 +: 32] = 32'd0;
    lif_vol[1*32 +: 32] = 32'd93;
    lif_vol[2*32 +: 32] = 32'd0;
    lif_vol[3*32 +: 32] = 32'd16;
    checkOutput("lif_cur", bus.cur_out, lif_cur);
    checkOutput("lif_vol", bus.vol_out, lif_vol);
    checkOutput("lif_spike", bus.spike_out, 16'h0005);
    tick();

    // Flush on the second RUN cycle
    applyStimulus(1'b0, 2'b11, splat(32'd5), splat(32'd1), splat(32'd7), 128'hFFFF, 32'd0);
    tick();
    bus.start = 1'b0;
    tick();
    bus.flush = 1'b1;
    #1;
    checkOutput("flush_cycle", {bus.busy, bus.done}, 2'b10);
    tick();
    bus.flush = 1'b0;
    #1;
    checkOutput("flush_ctrl", {bus.busy, bus.stall, bus.done}, 3'b000);
    checkOutput("flush_cur", bus.cur_out, lif_cur);
    checkOutput("flush_vol", bus.vol_out, lif_vol);
    checkOutput("flush_spike", bus.spike_out, 16'h0005);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done !== 1'b0) seen_done = 1'b1;
    end
    checkOutput("flush_no_done", seen_done, 1'b0);

    // Overflow on lanes 0 (positive) and 1 (negative)
    tmp_vec = '0;
    tmp_vec[0*32 +: 32] = 32'h7FFF_FFF0;
    tmp_vec[1*32 +: 32] = 32'h8000_0005;
    exp_vol = '0;
    exp_vol[0*32 +: 32] = 32'h0000_0020;
    exp_vol[1*32 +: 32] = 32'hFFFF_FFF0;
    applyStimulus(1'b0, 2'b00, tmp_vec, '0, exp_vol, 128'h0003, 32'd0);
    waitDone(20, 1'b1, lat);
    checkOutput("ovf_latency", 32'(lat), 32'd2);
    exp_cur = '0;
`ifdef NACC_SAT_EN
    exp_cur[0*32 +: 32] = 32'h7FFF_FFFF;
    exp_cur[1*32 +: 32] = 32'h8000_0000;
`else
    exp_cur[0*32 +: 32] = 32'h8000_0010;
    exp_cur[1*32 +: 32] = 32'h7FFF_FFF5;
`endif
    checkOutput("ovf_cur", bus.cur_out, exp_cur);
    tick();

    // Reset during RUN, then a normal op
    applyStimulus(1'b1, 2'b11, splat(32'd50), splat(32'd60), splat(32'd1), 128'hFFFF, 32'd10);
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_run_ctrl", {bus.busy, bus.stall, bus.done}, 3'b000);
    checkOutput("rst_run_cur", bus.cur_out, '0);
    checkOutput("rst_run_vol", bus.vol_out, '0);
    checkOutput("rst_run_spike", bus.spike_out, '0);
    applyStimulus(1'b0, 2'b01, splat(32'd3), splat(32'd9), splat(32'd4), 128'hFFFF, 32'd0);
    waitDone(20, 1'b1, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd3);
    exp_cur = splat(32'd3);
    for (int i = 0; i < 8; i++) exp_cur[i*32 +: 32] = 32'd7;
    checkOutput("post_rst_cur", bus.cur_out, exp_cur);
    checkOutput("post_rst_vol", bus.vol_out, splat(32'd9));
    tick();

    // Back-to-back with start held high
    applyStimulus(1'b0, 2'b11, splat(32'd1), splat(32'd0), splat(32'd2), 128'h0001, 32'd0);
    waitDone(20, 1'b0, lat);
    checkOutput("b2b_first_latency", 32'(lat), 32'd5);
    tick();
    checkOutput("b2b_accept", {bus.stall, bus.busy, bus.done}, 3'b100);
    waitDone(20, 1'b0, lat2);
    bus.start = 1'b0;
    checkOutput("b2b_gap", 32'(lat2 + 1), 32'd6);
    exp_cur = splat(32'd1);
    exp_cur[0*32 +: 32] = 32'd3;
    checkOutput("b2b_cur", bus.cur_out, exp_cur);
    tick();
    checkOutput("b2b_idle", {bus.busy, bus.done}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
